axi_reg_slice: RTL and testbench
================================

# axi_reg_slice

Full-throughput AXI4 register slice between the OpenPiton memory-side AXI4 master (NoC-to-AXI bridge) and the AWS shell DDR/PCIe AXI4 ports. It breaks every combinational valid/ready/payload path across the five channels, which lets the chipset-to-shell crossing close timing at the cl clock. Each channel is an independent 2-entry skid buffer. Each buffer adds 1 cycle of latency and sustains 1 beat/cycle.

## Interface
Parameters:
- REG_AW, default 1: 1 = skid buffer on AW; 0 = wire passthrough.
- REG_W, default 1: same, for the W channel.
- REG_B, default 1: same, for the B channel.
- REG_AR, default 1: same, for the AR channel.
- REG_R, default 1: same, for the R channel.

Ports:
- clk, input, 1: single clock for all channels.
- rst_n, input, 1: reset, asynchronous, active-low.
- s_axi, axi_bus_t.master modport: upstream side. Receives AW/W/AR and drives awready/wready/arready, plus B and R.
- m_axi, axi_bus_t.slave modport: downstream side toward the shell. Drives AW/W/AR and bready/rready, and receives B and R.
- All widths come from the `C_M_AXI4_*` macros in mc_define.h.

## Operation
- Forward channels (AW, W, AR) flow s_axi→m_axi. Reverse channels (B, R) flow m_axi→s_axi.
- Payload bundles per channel:
  - AW: id, addr, len, size, burst, lock, cache, prot, qos, region, user.
  - W: id, data, strb, last, user.
  - B: id, resp, user.
  - AR: same fields as AW.
  - R: id, data, resp, last, user.
- Every field is carried bit-exact. No reordering across or within channels.
- Per-channel skid buffer has 3 states, `in_rdy` and `out_vld` are registered, and "accept" and "take" are defined as:
  - accept = in_vld & in_rdy; take = out_vld & out_rdy.
  - EMPTY: out_vld=0, in_rdy=1. On accept, the payload goes to the main register → BUSY.
  - BUSY: out_vld=1, in_rdy=1.
    - accept & take: main ← new payload, stay BUSY.
    - accept & !take: skid ← new payload → FULL.
    - !accept & take → EMPTY.
    - neither: hold.
  - FULL: out_vld=1, in_rdy=0. On take, main ← skid → BUSY; otherwise hold.
- The output payload always comes from the main register. The skid register is only written in BUSY on accept & !take.
- Passthrough (REG_x=0): all signals of that channel are assigned combinationally; no state.
- No protocol checking. The block never generates or drops beats, and never alters wlast/rlast.

## Timing
- Reset (rst_n low, asynchronous):
  - every buffer goes to EMPTY;
  - m_axi awvalid/wvalid/arvalid = 0, bready = rready = 1;
  - s_axi bvalid/rvalid = 0, awready/wready/arready = 1.
- Payload registers are not reset. They are don't-care while the matching valid is 0.
- Latency: a beat accepted at edge N is presented on the output from cycle N+1 (registered channel).
- Throughput: 1 beat/cycle sustained while the output is ready every cycle.
- Backpressure:
  - out_rdy dropping costs at most one extra beat, which is held in skid.
  - in_rdy falls in the cycle after FULL is entered, i.e. registered with no combinational path from out_rdy.
- Valid stability (AXI rule): once out_vld=1 the output payload is held until take, in all states.
- Simultaneous accept & take in BUSY sustains full rate with no bubble.
- Reset mid-burst discards all buffered beats immediately. The reset is expected to be system-wide.

## Structure
- Shared package axi_reg_slice_pkg holds:
  - packed struct typedefs for the five channel payloads, built from the `C_M_AXI4_*` widths;
  - the state enum {EMPTY, BUSY, FULL}.
- Sub-module axi_skid_buf, parameterised by payload WIDTH: ports clk, rst_n, in_vld/in_rdy/in_data, out_vld/out_rdy/out_data.
- The top instantiates axi_skid_buf five times under generate-if on REG_x, and packs/unpacks the interface signals into the structs.

## Test plan
- Single AW beat, awaddr=0x0000_1000, awid=3, awlen=7, with m_axi awready=1: m_axi awvalid rises 1 cycle after the s_axi handshake with identical fields, and s_axi awready stays 1.
- 8-beat W burst with constant ready: 8 beats exit on 8 consecutive cycles starting 1 cycle late; wlast only on beat 8; data 0x..01–0x..08 in order.
- Backpressure: stream R beats 1..6 and drop rready for 3 cycles after beat 2 exits. One beat is held in skid, s_axi rready-equivalent (m_axi rready) goes 0 the next cycle, no beat is lost or duplicated, and the output sequence is 1..6.
- Randomised valid/ready on all five channels simultaneously for 10k cycles: per channel, the output sequence equals the input sequence and the payload is stable while valid & !ready.
- Assert rst_n low while W is FULL: all valids drop to 0 and the three forward readies go to 1 asynchronously. After release, the first new beat passes with 1-cycle latency.
- REG_B=0: bvalid/bready/bid propagate in the same cycle (0 latency); the other channels are unaffected.

Source files
------------

// File: rtl/axi_reg_slice_pkg.sv
// Shared widths, channel payload structs and skid-buffer state encoding for axi_reg_slice.
// Widths follow the C_M_AXI4_* macros; defaults apply when mc_define.h has not been read.
`ifndef C_M_AXI4_ID_WIDTH
`define C_M_AXI4_ID_WIDTH 6
`endif
`ifndef C_M_AXI4_ADDR_WIDTH
`define C_M_AXI4_ADDR_WIDTH 64
`endif
`ifndef C_M_AXI4_DATA_WIDTH
`define C_M_AXI4_DATA_WIDTH 512
`endif
`ifndef C_M_AXI4_STRB_WIDTH
`define C_M_AXI4_STRB_WIDTH 64
`endif
`ifndef C_M_AXI4_LEN_WIDTH
`define C_M_AXI4_LEN_WIDTH 8
`endif
`ifndef C_M_AXI4_SIZE_WIDTH
`define C_M_AXI4_SIZE_WIDTH 3
`endif
`ifndef C_M_AXI4_BURST_WIDTH
`define C_M_AXI4_BURST_WIDTH 2
`endif
`ifndef C_M_AXI4_LOCK_WIDTH
`define C_M_AXI4_LOCK_WIDTH 1
`endif
`ifndef C_M_AXI4_CACHE_WIDTH
`define C_M_AXI4_CACHE_WIDTH 4
`endif
`ifndef C_M_AXI4_PROT_WIDTH
`define C_M_AXI4_PROT_WIDTH 3
`endif
`ifndef C_M_AXI4_QOS_WIDTH
`define C_M_AXI4_QOS_WIDTH 4
`endif
`ifndef C_M_AXI4_REGION_WIDTH
`define C_M_AXI4_REGION_WIDTH 4
`endif
`ifndef C_M_AXI4_USER_WIDTH
`define C_M_AXI4_USER_WIDTH 11
`endif
`ifndef C_M_AXI4_RESP_WIDTH
`define C_M_AXI4_RESP_WIDTH 2
`endif

package axi_reg_slice_pkg;

    localparam int unsigned AxiIdWidth     = `C_M_AXI4_ID_WIDTH;
    localparam int unsigned AxiAddrWidth   = `C_M_AXI4_ADDR_WIDTH;
    localparam int unsigned AxiDataWidth   = `C_M_AXI4_DATA_WIDTH;
    localparam int unsigned AxiStrbWidth   = `C_M_AXI4_STRB_WIDTH;
    localparam int unsigned AxiLenWidth    = `C_M_AXI4_LEN_WIDTH;
    localparam int unsigned AxiSizeWidth   = `C_M_AXI4_SIZE_WIDTH;
    localparam int unsigned AxiBurstWidth  = `C_M_AXI4_BURST_WIDTH;
    localparam int unsigned AxiLockWidth   = `C_M_AXI4_LOCK_WIDTH;
    localparam int unsigned AxiCacheWidth  = `C_M_AXI4_CACHE_WIDTH;
    localparam int unsigned AxiProtWidth   = `C_M_AXI4_PROT_WIDTH;
    localparam int unsigned AxiQosWidth    = `C_M_AXI4_QOS_WIDTH;
    localparam int unsigned AxiRegionWidth = `C_M_AXI4_REGION_WIDTH;
    localparam int unsigned AxiUserWidth   = `C_M_AXI4_USER_WIDTH;
    localparam int unsigned AxiRespWidth   = `C_M_AXI4_RESP_WIDTH;

    typedef struct packed {
        logic [AxiIdWidth-1:0]     id;
        logic [AxiAddrWidth-1:0]   addr;
        logic [AxiLenWidth-1:0]    len;
        logic [AxiSizeWidth-1:0]   size;
        logic [AxiBurstWidth-1:0]  burst;
        logic [AxiLockWidth-1:0]   lock;
        logic [AxiCacheWidth-1:0]  cache;
        logic [AxiProtWidth-1:0]   prot;
        logic [AxiQosWidth-1:0]    qos;
        logic [AxiRegionWidth-1:0] region;
        logic [AxiUserWidth-1:0]   user;
    } ax_chan_t;

    typedef ax_chan_t aw_chan_t;
    typedef ax_chan_t ar_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [AxiStrbWidth-1:0] strb;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiRespWidth-1:0] resp;
        logic [AxiUserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [AxiRespWidth-1:0] resp;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } r_chan_t;

    // Encoding chosen so bit 1 is out_vld and bit 0 is !in_rdy straight from the state flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/axi_bus_t.sv
// AXI4 bundle between the OpenPiton memory-side bridge and the shell ports.
// master modport faces an upstream AXI master; slave modport faces a downstream AXI slave.
interface axi_bus_t;
    import axi_reg_slice_pkg::*;

    logic [AxiIdWidth-1:0]     awid;
    logic [AxiAddrWidth-1:0]   awaddr;
    logic [AxiLenWidth-1:0]    awlen;
    logic [AxiSizeWidth-1:0]   awsize;
    logic [AxiBurstWidth-1:0]  awburst;
    logic [AxiLockWidth-1:0]   awlock;
    logic [AxiCacheWidth-1:0]  awcache;
    logic [AxiProtWidth-1:0]   awprot;
    logic [AxiQosWidth-1:0]    awqos;
    logic [AxiRegionWidth-1:0] awregion;
    logic [AxiUserWidth-1:0]   awuser;
    logic                      awvalid;
    logic                      awready;

    logic [AxiIdWidth-1:0]     wid;
    logic [AxiDataWidth-1:0]   wdata;
    logic [AxiStrbWidth-1:0]   wstrb;
    logic                      wlast;
    logic [AxiUserWidth-1:0]   wuser;
    logic                      wvalid;
    logic                      wready;

    logic [AxiIdWidth-1:0]     bid;
    logic [AxiRespWidth-1:0]   bresp;
    logic [AxiUserWidth-1:0]   buser;
    logic                      bvalid;
    logic                      bready;

    logic [AxiIdWidth-1:0]     arid;
    logic [AxiAddrWidth-1:0]   araddr;
    logic [AxiLenWidth-1:0]    arlen;
    logic [AxiSizeWidth-1:0]   arsize;
    logic [AxiBurstWidth-1:0]  arburst;
    logic [AxiLockWidth-1:0]   arlock;
    logic [AxiCacheWidth-1:0]  arcache;
    logic [AxiProtWidth-1:0]   arprot;
    logic [AxiQosWidth-1:0]    arqos;
    logic [AxiRegionWidth-1:0] arregion;
    logic [AxiUserWidth-1:0]   aruser;
    logic                      arvalid;
    logic                      arready;

    logic [AxiIdWidth-1:0]     rid;
    logic [AxiDataWidth-1:0]   rdata;
    logic [AxiRespWidth-1:0]   rresp;
    logic                      rlast;
    logic [AxiUserWidth-1:0]   ruser;
    logic                      rvalid;
    logic                      rready;

    modport master (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
               awuser, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
               aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );

    modport slave (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
               awuser, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
               aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

endinterface

// File: rtl/axi_skid_buf.sv
// Two-entry skid buffer: registered in_rdy/out_vld, one cycle latency, one beat per cycle.
module axi_skid_buf
    import axi_reg_slice_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             accept, take;
    logic             main_load, main_from_skid, skid_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (main_load) begin
            main_q <= main_from_skid ? skid_q : in_data;
        end
        if (skid_load) begin
            skid_q <= in_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        accept         = in_vld & in_rdy;
        take           = out_vld & out_rdy;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (accept && take) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (take) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_vld  = state_q[1];
        in_rdy   = ~state_q[0];
        out_data = main_q;
    end

endmodule

// File: rtl/axi_reg_slice.sv
// AXI4 register slice: one independent skid buffer (or a wire) per channel, AW/W/AR forward,
// B/R reverse.
module axi_reg_slice
    import axi_reg_slice_pkg::*;
#(
    parameter bit REG_AW = 1'b1,
    parameter bit REG_W  = 1'b1,
    parameter bit REG_B  = 1'b1,
    parameter bit REG_AR = 1'b1,
    parameter bit REG_R  = 1'b1
) (
    input logic      clk,
    input logic      rst_n,
    axi_bus_t.master s_axi,
    axi_bus_t.slave  m_axi
);

    aw_chan_t aw_in, aw_out;
    w_chan_t  w_in, w_out;
    b_chan_t  b_in, b_out;
    ar_chan_t ar_in, ar_out;
    r_chan_t  r_in, r_out;

    assign aw_in = '{id: s_axi.awid, addr: s_axi.awaddr, len: s_axi.awlen, size: s_axi.awsize,
                     burst: s_axi.awburst, lock: s_axi.awlock, cache: s_axi.awcache,
                     prot: s_axi.awprot, qos: s_axi.awqos, region: s_axi.awregion,
                     user: s_axi.awuser};
    assign w_in  = '{id: s_axi.wid, data: s_axi.wdata, strb: s_axi.wstrb, last: s_axi.wlast,
                     user: s_axi.wuser};
    assign b_in  = '{id: m_axi.bid, resp: m_axi.bresp, user: m_axi.buser};
    assign ar_in = '{id: s_axi.arid, addr: s_axi.araddr, len: s_axi.arlen, size: s_axi.arsize,
                     burst: s_axi.arburst, lock: s_axi.arlock, cache: s_axi.arcache,
                     prot: s_axi.arprot, qos: s_axi.arqos, region: s_axi.arregion,
                     user: s_axi.aruser};
    assign r_in  = '{id: m_axi.rid, data: m_axi.rdata, resp: m_axi.rresp, last: m_axi.rlast,
                     user: m_axi.ruser};

    assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.awlock,
            m_axi.awcache, m_axi.awprot, m_axi.awqos, m_axi.awregion, m_axi.awuser} = aw_out;
    assign {m_axi.wid, m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wuser} = w_out;
    assign {s_axi.bid, s_axi.bresp, s_axi.buser} = b_out;
    assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arlock,
            m_axi.arcache, m_axi.arprot, m_axi.arqos, m_axi.arregion, m_axi.aruser} = ar_out;
    assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.ruser} = r_out;

    if (REG_AW) begin : g_aw_reg
        axi_skid_buf #(.WIDTH($bits(aw_chan_t))) u_aw_buf (
            .clk(clk), .rst_n(rst_n),
            .in_vld(s_axi.awvalid), .in_rdy(s_axi.awready), .in_data(aw_in),
            .out_vld(m_axi.awvalid), .out_rdy(m_axi.awready), .out_data(aw_out)
        );
    end else begin : g_aw_pass
        assign m_axi.awvalid = s_axi.awvalid;
        assign s_axi.awready = m_axi.awready;
        assign aw_out        = aw_in;
    end

    if (REG_W) begin : g_w_reg
        axi_skid_buf #(.WIDTH($bits(w_chan_t))) u_w_buf (
            .clk(clk), .rst_n(rst_n),
            .in_vld(s_axi.wvalid), .in_rdy(s_axi.wready), .in_data(w_in),
            .out_vld(m_axi.wvalid), .out_rdy(m_axi.wready), .out_data(w_out)
        );
    end else begin : g_w_pass
        assign m_axi.wvalid = s_axi.wvalid;
        assign s_axi.wready = m_axi.wready;
        assign w_out        = w_in;
    end

    if (REG_B) begin : g_b_reg
        axi_skid_buf #(.WIDTH($bits(b_chan_t))) u_b_buf (
            .clk(clk), .rst_n(rst_n),
            .in_vld(m_axi.bvalid), .in_rdy(m_axi.bready), .in_data(b_in),
            .out_vld(s_axi.bvalid), .out_rdy(s_axi.bready), .out_data(b_out)
        );
    end else begin : g_b_pass
        assign s_axi.bvalid = m_axi.bvalid;
        assign m_axi.bready = s_axi.bready;
        assign b_out        = b_in;
    end

    if (REG_AR) begin : g_ar_reg
        axi_skid_buf #(.WIDTH($bits(ar_chan_t))) u_ar_buf (
            .clk(clk), .rst_n(rst_n),
            .in_vld(s_axi.arvalid), .in_rdy(s_axi.arready), .in_data(ar_in),
            .out_vld(m_axi.arvalid), .out_rdy(m_axi.arready), .out_data(ar_out)
        );
    end else begin : g_ar_pass
        assign m_axi.arvalid = s_axi.arvalid;
        assign s_axi.arready = m_axi.arready;
        assign ar_out        = ar_in;
    end

    if (REG_R) begin : g_r_reg
        axi_skid_buf #(.WIDTH($bits(r_chan_t))) u_r_buf (
            .clk(clk), .rst_n(rst_n),
            .in_vld(m_axi.rvalid), .in_rdy(m_axi.rready), .in_data(r_in),
            .out_vld(s_axi.rvalid), .out_rdy(s_axi.rready), .out_data(r_out)
        );
    end else begin : g_r_pass
        assign s_axi.rvalid = m_axi.rvalid;
        assign m_axi.rready = s_axi.rready;
        assign r_out        = r_in;
    end

endmodule

// File: tb/tb_axi_reg_slice.sv
// Directed bench for axi_reg_slice: reset, latency, bursts, backpressure, random AR/R streams,
// asynchronous reset while FULL, and a REG_B=0 passthrough instance.
module tb_axi_reg_slice;
    import axi_reg_slice_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    axi_bus_t s_if ();
    axi_bus_t m_if ();
    axi_bus_t s2_if ();
    axi_bus_t m2_if ();

    axi_reg_slice u_dut (
        .clk(clk), .rst_n(rst_n), .s_axi(s_if), .m_axi(m_if)
    );

    axi_reg_slice #(.REG_B(1'b0)) u_dut_pt (
        .clk(clk), .rst_n(rst_n), .s_axi(s2_if), .m_axi(m2_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic init_bus();
        s_if.awvalid = 1'b0;  s_if.awaddr = '0;  s_if.awid = '0;  s_if.awlen = '0;
        s_if.wvalid  = 1'b0;  s_if.wdata  = '0;  s_if.wlast = 1'b0;
        s_if.arvalid = 1'b0;  s_if.araddr = '0;
        s_if.bready  = 1'b1;  s_if.rready = 1'b1;
        m_if.awready = 1'b1;  m_if.wready = 1'b1; m_if.arready = 1'b1;
        m_if.bvalid  = 1'b0;  m_if.bid = '0;  m_if.bresp = '0;
        m_if.rvalid  = 1'b0;  m_if.rdata = '0;  m_if.rlast = 1'b0;
        s2_if.awvalid = 1'b0; s2_if.awaddr = '0; s2_if.wvalid = 1'b0; s2_if.arvalid = 1'b0;
        s2_if.bready  = 1'b1; s2_if.rready = 1'b1;
        m2_if.awready = 1'b1; m2_if.wready = 1'b1; m2_if.arready = 1'b1;
        m2_if.bvalid  = 1'b0; m2_if.bid = '0; m2_if.rvalid = 1'b0;
    endtask

    // Backpressure trace, indexed by cycle from the first R beat.
    logic       exp_mrrdy [11] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    logic       exp_svld  [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int         exp_sdat  [11] = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 0};

    int          r_idx, n_out;
    int          ar_in, ar_out, r_in, r_out;
    logic        ar_hold, ar_pend, r_hold, r_pend;
    logic [63:0] ar_prev, r_prev;

    initial begin
        init_bus();

        // Reset state
        #1;
        chk("rst_fwd_valid", {m_if.awvalid, m_if.wvalid, m_if.arvalid}, 3'b000);
        chk("rst_fwd_ready", {s_if.awready, s_if.wready, s_if.arready}, 3'b111);
        chk("rst_rev_valid", {s_if.bvalid, s_if.rvalid}, 2'b00);
        chk("rst_rev_ready", {m_if.bready, m_if.rready}, 2'b11);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single AW beat
        s_if.awvalid = 1'b1; s_if.awaddr = 64'h1000; s_if.awid = 3; s_if.awlen = 7;
        #1;
        chk("aw_pre_valid", m_if.awvalid, 0);
        chk("aw_ready", s_if.awready, 1);
        @(negedge clk);
        s_if.awvalid = 1'b0; s_if.awaddr = '0; s_if.awid = '0; s_if.awlen = '0;
        #1;
        chk("aw_valid", m_if.awvalid, 1);
        chk("aw_addr", m_if.awaddr, 64'h1000);
        chk("aw_id", 64'(m_if.awid), 3);
        chk("aw_len", 64'(m_if.awlen), 7);
        chk("aw_ready_hold", s_if.awready, 1);
        @(negedge clk);
        #1;
        chk("aw_drain", m_if.awvalid, 0);

        // 8-beat W burst, constant ready
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            s_if.wvalid = (i < 8);
            s_if.wdata  = 512'(i + 1);
            s_if.wlast  = (i == 7);
            #1;
            if (i == 0) begin
                chk("w_first_lat", m_if.wvalid, 0);
            end else begin
                chk($sformatf("w_valid_%0d", i), m_if.wvalid, 1);
                chk($sformatf("w_data_%0d", i), m_if.wdata[63:0], 64'(i));
                chk($sformatf("w_last_%0d", i), m_if.wlast, (i == 8));
            end
        end
        @(negedge clk);
        s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
        #1;
        chk("w_drain", m_if.wvalid, 0);

        // B: registered on u_dut, passthrough on u_dut_pt; AW on u_dut_pt still registered
        @(negedge clk);
        m_if.bvalid  = 1'b1; m_if.bid  = 5; m_if.bresp  = 2; s_if.bready  = 1'b0;
        m2_if.bvalid = 1'b1; m2_if.bid = 5; m2_if.bresp = 2; s2_if.bready = 1'b0;
        s2_if.awvalid = 1'b1; s2_if.awaddr = 64'h2000;
        #1;
        chk("b_reg_lat", s_if.bvalid, 0);
        chk("b_pt_valid", s2_if.bvalid, 1);
        chk("b_pt_id", 64'(s2_if.bid), 5);
        chk("b_pt_resp", 64'(s2_if.bresp), 2);
        chk("b_pt_ready_lo", m2_if.bready, 0);
        chk("pt_aw_lat", m2_if.awvalid, 0);
        s2_if.bready = 1'b1;
        #1;
        chk("b_pt_ready_hi", m2_if.bready, 1);
        @(negedge clk);
        m_if.bvalid = 1'b0; m2_if.bvalid = 1'b0; s2_if.awvalid = 1'b0; m_if.bid = '0;
        #1;
        chk("b_reg_valid", s_if.bvalid, 1);
        chk("b_reg_id", 64'(s_if.bid), 5);
        chk("b_pt_drop", s2_if.bvalid, 0);
        chk("pt_aw_valid", m2_if.awvalid, 1);
        chk("pt_aw_addr", m2_if.awaddr, 64'h2000);
        s_if.bready = 1'b1;
        @(negedge clk);
        #1;
        chk("b_reg_drain", s_if.bvalid, 0);

        // R backpressure: beats 1..6, sink stalls for 3 cycles after beat 2 exits
        r_idx = 1;
        n_out = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            m_if.rvalid = (r_idx <= 6);
            m_if.rdata  = 512'(r_idx);
            m_if.rlast  = (r_idx == 6);
            s_if.rready = !(c >= 3 && c <= 5);
            #1;
            chk($sformatf("bp_mrready_c%0d", c), m_if.rready, exp_mrrdy[c]);
            chk($sformatf("bp_svalid_c%0d", c), s_if.rvalid, exp_svld[c]);
            if (exp_svld[c]) begin
                chk($sformatf("bp_sdata_c%0d", c), s_if.rdata[63:0], 64'(exp_sdat[c]));
            end
            if (s_if.rvalid && s_if.rready) begin
                n_out++;
                chk("bp_seq", s_if.rdata[63:0], 64'(n_out));
                chk("bp_last", s_if.rlast, (n_out == 6));
            end
            if (m_if.rvalid && m_if.rready) r_idx++;
        end
        chk("bp_count", 64'(n_out), 6);
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s_if.rready = 1'b1;

        // Random valid/ready on AR (forward) and R (reverse), then a short drain
        ar_in = 0; ar_out = 0; r_in = 0; r_out = 0;
        ar_hold = 1'b0; ar_pend = 1'b0; r_hold = 1'b0; r_pend = 1'b0;
        ar_prev = '0; r_prev = '0;
        for (int cyc = 0; cyc < 2006; cyc++) begin
            @(negedge clk);
            if (cyc >= 2000) begin
                s_if.arvalid = 1'b0; m_if.arready = 1'b1;
                m_if.rvalid  = 1'b0; s_if.rready  = 1'b1;
            end else begin
                if (!ar_hold) s_if.arvalid = 1'($urandom_range(0, 1));
                if (!r_hold)  m_if.rvalid  = 1'($urandom_range(0, 1));
                m_if.arready = 1'($urandom_range(0, 1));
                s_if.rready  = 1'($urandom_range(0, 1));
            end
            s_if.araddr = 64'(ar_in) + 64'h100;
            m_if.rdata  = 512'(r_in) + 512'h7000;
            #1;
            if (ar_pend) begin
                chk("rnd_ar_hold_valid", m_if.arvalid, 1);
                chk("rnd_ar_hold_addr", m_if.araddr, ar_prev);
            end
            if (r_pend) begin
                chk("rnd_r_hold_valid", s_if.rvalid, 1);
                chk("rnd_r_hold_data", s_if.rdata[63:0], r_prev);
            end
            if (m_if.arvalid && m_if.arready) begin
                chk("rnd_ar_order", m_if.araddr, 64'(ar_out) + 64'h100);
                ar_out++;
            end
            if (s_if.rvalid && s_if.rready) begin
                chk("rnd_r_order", s_if.rdata[63:0], 64'(r_out) + 64'h7000);
                r_out++;
            end
            if (s_if.arvalid && s_if.arready) ar_in++;
            if (m_if.rvalid && m_if.rready) r_in++;
            ar_hold = s_if.arvalid && !s_if.arready;
            r_hold  = m_if.rvalid && !m_if.rready;
            ar_pend = m_if.arvalid && !m_if.arready;
            r_pend  = s_if.rvalid && !s_if.rready;
            ar_prev = m_if.araddr;
            r_prev  = s_if.rdata[63:0];
        end
        chk("rnd_ar_count", 64'(ar_out), 64'(ar_in));
        chk("rnd_r_count", 64'(r_out), 64'(r_in));
        chk("rnd_ar_nonzero", 64'(ar_in > 100), 1);

        // Fill W to FULL (and AW to BUSY), then assert reset between clock edges
        @(negedge clk);
        m_if.wready = 1'b0; m_if.awready = 1'b0;
        s_if.wvalid = 1'b1; s_if.wdata = 512'h11;
        s_if.awvalid = 1'b1; s_if.awaddr = 64'h3000;
        @(negedge clk);
        s_if.wdata = 512'h22; s_if.awvalid = 1'b0;
        @(negedge clk);
        #1;
        chk("wfull_ready", s_if.wready, 0);
        chk("wfull_valid", m_if.wvalid, 1);
        chk("wfull_data", m_if.wdata[63:0], 64'h11);
        chk("awbusy_valid", m_if.awvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valids", {m_if.awvalid, m_if.wvalid, m_if.arvalid}, 3'b000);
        chk("arst_readies", {s_if.awready, s_if.wready, s_if.arready}, 3'b111);
        s_if.wvalid = 1'b0; m_if.wready = 1'b1; m_if.awready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s_if.wvalid = 1'b1; s_if.wdata = 512'hAA; s_if.wlast = 1'b1;
        #1;
        chk("post_rst_lat", m_if.wvalid, 0);
        @(negedge clk);
        s_if.wvalid = 1'b0; s_if.wdata = '0;
        #1;
        chk("post_rst_valid", m_if.wvalid, 1);
        chk("post_rst_data", m_if.wdata[63:0], 64'hAA);
        @(negedge clk);
        #1;
        chk("post_rst_drain", m_if.wvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
